regfile_mp: RTL

- Parametrised multi-port CPU register file; next generation of the 32x32 single-write, two-read register file.
- Adds the following over that block:
  - configurable width, depth and read/write port counts;
  - hardwired-zero r0;
  - write-to-read bypass;
  - per-register pending scoreboard, so the decode stage can stall on registers awaiting a multi-cycle result (load, mul/div).
- Sits between decode (read ports, reserve port) and writeback (write ports).

---
 rtl/regfile_pkg.sv | 29 ++
 rtl/regfile_rd_port.sv | 59 +++++
 rtl/regfile_mp.sv | 126 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared definitions for the multi-port register file and the
//               decode / hazard logic around it: default geometry, the
//               hardwired-zero register address and packed-port slicing
//               helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Architectural zero register.
    localparam int REG_ZERO   = 0;

    // Low bit of field 'idx' in a vector packing fields of 'width' bits each.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

    // High bit of the same field.
    function automatic int slice_hi(input int idx, input int width);
        return (idx * width) + width - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rd_port
// Description : One read port of regfile_mp. It selects the stored word,
//               optionally forwards a same-cycle write, forces r0 to zero,
//               and reports whether the value is final (not pending).
// Ports       : i_raddr  - read address
//               i_regs   - flattened register array (reg k at k*DATA_W)
//               i_pend   - per-register pending flags
//               i_we/i_waddr/i_wdata - write ports, used for the bypass
//               o_rdata  - read data (combinational)
//               o_rready - 1 when o_rdata is final
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rd_port #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_WR  = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic [ADDR_W-1:0]               i_raddr,
    input  logic [(2**ADDR_W)*DATA_W-1:0]   i_regs,
    input  logic [(2**ADDR_W)-1:0]          i_pend,
    input  logic [NUM_WR-1:0]               i_we,
    input  logic [NUM_WR*ADDR_W-1:0]        i_waddr,
    input  logic [NUM_WR*DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]               o_rdata,
    output logic                            o_rready
);
    import regfile_pkg::*;

    logic [DATA_W-1:0] w_rdata;
    logic              w_rready;

    always_comb begin
        w_rdata  = i_regs[slice_lo(int'(i_raddr), DATA_W) +: DATA_W];
        w_rready = ~i_pend[i_raddr];
        // Ascending scan: the highest-index matching write port wins.
        if (BYPASS != 0) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (i_we[j] && (i_waddr[slice_lo(j, ADDR_W) +: ADDR_W] == i_raddr)) begin
                    w_rdata  = i_wdata[slice_lo(j, DATA_W) +: DATA_W];
                    w_rready = 1'b1;
                end
            end
        end
        // r0 overrides everything, including a forwarded write to it.
        if ((ZERO_R0 != 0) && (i_raddr == ADDR_W'(REG_ZERO))) begin
            w_rdata  = '0;
            w_rready = 1'b1;
        end
    end

    assign o_rdata  = w_rdata;
    assign o_rready = w_rready;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port register file with optional
//               hardwired-zero r0, write-to-read bypass and a per-register
//               pending scoreboard for multi-cycle producers.
// Ports       : clk      - rising-edge clock
//               rst      - asynchronous active-low reset
//               we/waddr/wdata - NUM_WR packed write ports
//               rsv_en/rsv_addr - mark one register pending
//               raddr    - NUM_RD packed read addresses
//               rdata    - NUM_RD packed read data (combinational)
//               rready   - per read port, 1 = value is final
//               pend_cnt - registered count of pending registers
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int NUM_WR  = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rready,
    output logic [ADDR_W:0]          pend_cnt
);
    import regfile_pkg::*;

    localparam int C_DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]         r_regs [C_DEPTH];
    logic [C_DEPTH-1:0]        r_pend;
    logic [ADDR_W:0]           r_pend_cnt;

    logic [C_DEPTH-1:0]        w_pend_next;
    logic [ADDR_W:0]           w_pend_cnt_next;
    logic [NUM_WR-1:0]         w_wr_eff;
    logic                      w_rsv_eff;
    logic [C_DEPTH*DATA_W-1:0] w_regs_flat;

    // Writes and reserves that actually land (r0 is immune when hardwired).
    always_comb begin
        for (int j = 0; j < NUM_WR; j++) begin
            w_wr_eff[j] = we[j] &&
                !((ZERO_R0 != 0) && (waddr[slice_lo(j, ADDR_W) +: ADDR_W] == ADDR_W'(REG_ZERO)));
        end
        w_rsv_eff = rsv_en && !((ZERO_R0 != 0) && (rsv_addr == ADDR_W'(REG_ZERO)));
    end

    // Writes clear first, then the reserve sets: a same-cycle reserve is a
    // newer producer than the completing write, so the register stays pending.
    always_comb begin
        w_pend_next = r_pend;
        for (int j = 0; j < NUM_WR; j++) begin
            if (w_wr_eff[j]) begin
                w_pend_next[waddr[slice_lo(j, ADDR_W) +: ADDR_W]] = 1'b0;
            end
        end
        if (w_rsv_eff) begin
            w_pend_next[rsv_addr] = 1'b1;
        end
        w_pend_cnt_next = '0;
        for (int k = 0; k < C_DEPTH; k++) begin
            w_pend_cnt_next = w_pend_cnt_next + {{ADDR_W{1'b0}}, w_pend_next[k]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < C_DEPTH; k++) begin
                r_regs[k] <= '0;
            end
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            // Later ports are scheduled last, so the highest index wins.
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wr_eff[j]) begin
                    r_regs[waddr[slice_lo(j, ADDR_W) +: ADDR_W]] <=
                        wdata[slice_lo(j, DATA_W) +: DATA_W];
                end
            end
            r_pend     <= w_pend_next;
            r_pend_cnt <= w_pend_cnt_next;
        end
    end

    generate
        for (genvar k = 0; k < C_DEPTH; k++) begin : g_flat
            assign w_regs_flat[k*DATA_W +: DATA_W] = r_regs[k];
        end

        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            regfile_rd_port #(
                .DATA_W  (DATA_W),
                .ADDR_W  (ADDR_W),
                .NUM_WR  (NUM_WR),
                .ZERO_R0 (ZERO_R0),
                .BYPASS  (BYPASS)
            ) u_rd_port (
                .i_raddr  (raddr[i*ADDR_W +: ADDR_W]),
                .i_regs   (w_regs_flat),
                .i_pend   (r_pend),
                .i_we     (we),
                .i_waddr  (waddr),
                .i_wdata  (wdata),
                .o_rdata  (rdata[i*DATA_W +: DATA_W]),
                .o_rready (rready[i])
            );
        end
    endgenerate

    assign pend_cnt = r_pend_cnt;

endmodule
`default_nettype wire
